// File: rtl/modexp_pkg.sv
// modexp_pkg: state encoding and shared constants for the modular exponentiation controller
package modexp_pkg;
    typedef enum logic [2:0] {
        IDLE,
        SQR_ISSUE,
        SQR_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        POST_ISSUE,
        POST_WAIT,
        DONE
    } state_t;
    localparam int unsigned ONE_W = 512;
    localparam logic [ONE_W-1:0] ONE = ONE_W'(1);
endpackage

// File: rtl/modexp_bit_counter.sv
// modexp_bit_counter: exponent bit index with clamped load, decrement and current-bit select
module modexp_bit_counter
    import modexp_pkg::*;
#(
    parameter int WORD_LEN = 512,
    parameter int CNT_W    = $clog2(WORD_LEN) + 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                load,
    input  logic                dec,
    input  logic [CNT_W-1:0]    len,
    input  logic [WORD_LEN-1:0] e,
    output logic                last,
    output logic                len_zero,
    output logic                cur_bit
);
    logic [CNT_W-1:0]    i;
    logic [CNT_W-1:0]    clamped;
    logic [WORD_LEN-1:0] shifted;
    // clamp the requested length and pick E[i-1] without an oversized index
    always_comb begin
        clamped  = (len > CNT_W'(WORD_LEN)) ? CNT_W'(WORD_LEN) : len;
        shifted  = e >> (i - CNT_W'(1));
        len_zero = (len == '0);
        last     = (i == CNT_W'(1));
        cur_bit  = (i == '0) ? 1'b0 : shifted[0];
    end
    // bit index: loaded on accepted start, stepped down after each processed bit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            i <= '0;
        else if (load)
            i <= clamped;
        else if (dec)
            i <= i - CNT_W'(1);
    end
endmodule

// File: rtl/modexp_controller.sv
// modexp_controller: left-to-right square-and-multiply sequencer around an external Montgomery multiplier (MODEXP_CONST_TIME_EN: always issue the multiply, discard on zero bits)
module modexp_controller
    import modexp_pkg::*;
#(
    parameter int WORD_LEN = 512,
    parameter int CNT_W    = $clog2(WORD_LEN) + 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [WORD_LEN-1:0] x_tilde,
    input  logic [WORD_LEN-1:0] a_init,
    input  logic [WORD_LEN-1:0] exp,
    input  logic [CNT_W-1:0]    exp_len,
    output logic                busy,
    output logic                done,
    output logic [WORD_LEN-1:0] result,
    output logic                mm_start,
    output logic [WORD_LEN-1:0] mm_in_a,
    output logic [WORD_LEN-1:0] mm_in_b,
    input  logic                mm_done,
    input  logic [WORD_LEN-1:0] mm_result
);
    state_t              state, state_nx;
    logic [WORD_LEN-1:0] acc, xt, e_reg, a_one;
    logic                last, len_zero, cur_bit;
    logic                accept, sq_done, mul_done, take_mul, dec;

`ifdef MODEXP_CONST_TIME_EN
    assign take_mul = 1'b1;
`else
    assign take_mul = cur_bit;
`endif

    assign accept   = (state == IDLE) && start;
    assign sq_done  = (state == SQR_WAIT) && mm_done;
    assign mul_done = (state == MUL_WAIT) && mm_done;
    assign dec      = (sq_done && !take_mul) || mul_done;

    modexp_bit_counter #(.WORD_LEN(WORD_LEN), .CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .load     (accept),
        .dec      (dec),
        .len      (exp_len),
        .e        (e_reg),
        .last     (last),
        .len_zero (len_zero),
        .cur_bit  (cur_bit)
    );

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next state and multiplier handshake; operands stay put across ISSUE and WAIT
    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == DONE);
        mm_start = 1'b0;
        mm_in_a  = '0;
        mm_in_b  = '0;
        case (state)
            IDLE:       if (start) state_nx = len_zero ? POST_ISSUE : SQR_ISSUE;
            SQR_ISSUE:  state_nx = SQR_WAIT;
            SQR_WAIT:   if (mm_done) state_nx = take_mul ? MUL_ISSUE : (last ? POST_ISSUE : SQR_ISSUE);
            MUL_ISSUE:  state_nx = MUL_WAIT;
            MUL_WAIT:   if (mm_done) state_nx = last ? POST_ISSUE : SQR_ISSUE;
            POST_ISSUE: state_nx = POST_WAIT;
            POST_WAIT:  if (mm_done) state_nx = DONE;
            DONE:       state_nx = IDLE;
        endcase
        case (state)
            SQR_ISSUE, SQR_WAIT: begin
                mm_start = (state == SQR_ISSUE);
                mm_in_a  = acc;
                mm_in_b  = acc;
            end
            MUL_ISSUE, MUL_WAIT: begin
                mm_start = (state == MUL_ISSUE);
                mm_in_a  = acc;
                mm_in_b  = cur_bit ? xt : a_one;
            end
            POST_ISSUE, POST_WAIT: begin
                mm_start = (state == POST_ISSUE);
                mm_in_a  = acc;
                mm_in_b  = WORD_LEN'(ONE);
            end
            default: ;
        endcase
    end

    // operand latch, accumulator update and final result capture
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc    <= '0;
            xt     <= '0;
            e_reg  <= '0;
            a_one  <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                xt    <= x_tilde;
                acc   <= a_init;
                a_one <= a_init;
                e_reg <= exp;
            end
            if (sq_done || (mul_done && cur_bit))
                acc <= mm_result;
            if ((state == POST_WAIT) && mm_done)
                result <= mm_result;
        end
    end
endmodule

// File: tb/tb_modexp_controller.sv
// tb_modexp_controller: directed checks of modexp_controller with a behavioural Montgomery multiplier (M=0xC5, L=3)
module tb_modexp_controller;
    localparam int WL = 16;
    localparam int CW = $clog2(WL) + 1;
    localparam logic [WL-1:0] M = 16'h00C5;
`ifdef MODEXP_CONST_TIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [WL-1:0] x_tilde = '0, a_init = '0, exp_v = '0;
    logic [CW-1:0] exp_len = '0;
    logic          busy, done, mm_start;
    logic [WL-1:0] result, mm_in_a, mm_in_b;
    logic          mm_done;
    logic [WL-1:0] mm_result;
    logic [WL-1:0] cap_a, cap_b;
    int            pend;
    int            total = 0, bad = 0;
    int            cyc = 0, n_start = 0, n_done = 0;

    always #5 clk = ~clk;

    modexp_controller #(.WORD_LEN(WL), .CNT_W(CW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .x_tilde   (x_tilde),
        .a_init    (a_init),
        .exp       (exp_v),
        .exp_len   (exp_len),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .mm_start  (mm_start),
        .mm_in_a   (mm_in_a),
        .mm_in_b   (mm_in_b),
        .mm_done   (mm_done),
        .mm_result (mm_result)
    );

    function automatic logic [WL-1:0] mont(input logic [WL-1:0] a, input logic [WL-1:0] b);
        logic [31:0] t;
        t = (32'(a) * 32'(b)) % 32'(M);
        for (int k = 0; k < WL; k++)
            t = t[0] ? (t + 32'(M)) >> 1 : t >> 1;
        return t[WL-1:0];
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend      <= 0;
            mm_done   <= 1'b0;
            mm_result <= '0;
            cap_a     <= '0;
            cap_b     <= '0;
        end else begin
            mm_done <= 1'b0;
            if (mm_start) begin
                pend  <= 2;
                cap_a <= mm_in_a;
                cap_b <= mm_in_b;
            end else if (pend == 1) begin
                pend      <= 0;
                mm_done   <= 1'b1;
                mm_result <= mont(cap_a, cap_b);
            end else if (pend > 1) begin
                pend <= pend - 1;
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mm_start) n_start <= n_start + 1;
        if (done) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic kick(input logic [WL-1:0] e, input logic [CW-1:0] t);
        x_tilde = 16'd2;
        a_init  = 16'd132;
        exp_v   = e;
        exp_len = t;
        start   = 1'b1;
    endtask

    task automatic run(input string tag, input logic [WL-1:0] e, input logic [CW-1:0] t, input int poke,
                       output logic [WL-1:0] res, output int ops, output int lat, output int ndn);
        int s0, d0, c0;
        @(negedge clk);
        kick(e, t);
        s0 = n_start;
        d0 = n_done;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        lat = -1;
        for (int k = 0; k < 3000 && lat < 0; k++) begin
            if (done) lat = cyc - c0 + 1;
            else begin
                if (k == poke) begin
                    start   = 1'b1;
                    exp_v   = '1;
                    exp_len = CW'(16);
                end
                @(negedge clk);
                start = 1'b0;
            end
        end
        res = result;
        @(negedge clk);
        @(negedge clk);
        ops = n_start - s0;
        ndn = n_done - d0;
    endtask

    initial begin
        logic [WL-1:0] res;
        int ops, lat, ndn;
        bit found;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mm_start", mm_start, 0);
        chk("rst_result", result, 0);
        @(negedge clk);
        resetn = 1'b1;

        run("e5", 16'h0005, CW'(3), -1, res, ops, lat, ndn);
        chk("e5_result", res, 16'h002E);
        chk("e5_ops", ops, CT ? 7 : 6);
        chk("e5_lat", lat, CT ? 30 : 26);
        chk("e5_done_pulses", ndn, 1);

        run("eB", 16'h000B, CW'(4), -1, res, ops, lat, ndn);
        chk("eB_result", res, 16'h002C);
        chk("eB_ops", ops, CT ? 9 : 8);
        chk("eB_lat", lat, CT ? 38 : 34);
        chk("eB_idle_after", busy, 0);

        run("t0", 16'h0005, CW'(0), -1, res, ops, lat, ndn);
        chk("t0_result", res, 16'h0001);
        chk("t0_ops", ops, 1);
        chk("t0_lat", lat, 6);
        chk("t0_op_a", cap_a, 16'd132);
        chk("t0_op_b", cap_b, 16'd1);

        run("poke", 16'h0005, CW'(3), 5, res, ops, lat, ndn);
        chk("poke_result", res, 16'h002E);
        chk("poke_ops", ops, CT ? 7 : 6);
        chk("poke_done_pulses", ndn, 1);

        run("clamp", 16'h0005, CW'(20), -1, res, ops, lat, ndn);
        chk("clamp_result", res, 16'h002E);
        chk("clamp_ops", ops, CT ? 33 : 19);

        @(negedge clk);
        kick(16'h0005, CW'(3));
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (mm_start) found = 1'b1;
            else @(negedge clk);
        end
        chk("ar_issue_seen", found, 1);
        @(negedge clk);
        chk("ar_pre_busy", busy, 1);
        resetn = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_mm_start", mm_start, 0);
        chk("ar_mm_in_a", mm_in_a, 0);
        chk("ar_mm_in_b", mm_in_b, 0);
        chk("ar_result", result, 0);
        @(negedge clk);
        resetn = 1'b1;

        run("post_rst", 16'h000B, CW'(4), -1, res, ops, lat, ndn);
        chk("post_rst_result", res, 16'h002C);
        chk("post_rst_ops", ops, CT ? 9 : 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
